// File: rtl/conv_fc_engine.sv
// ----------------------------------------------------------------------------
// conv_fc_engine
// Masked-sum engine shared by a convolution phase and a fully-connected phase.
// Each frame consists of CONV_BEATS conv beats. These are followed by FC_BEATS
// fc beats, and every fc beat needs its own weight set to be granted first.
// For each output channel, the engine adds up the operands whose mask bit is
// set. The result comes out of a two-register pipeline.
//
// Optional feature (macro CONV_FC_ACC_EN):
//   defined   -> each channel accumulates all fc beats of a frame. A single
//                out_fc_valid is produced together with frame_done.
//   undefined -> one out_fc_valid per fc beat.
//
// Ports:
//   clk            clock, rising edge
//   rstn           synchronous active-low reset
//   in_valid       input beat offered
//   in_ready       engine accepts the beat (transfer on in_valid & in_ready)
//   weight_req     requests the next fc weight set
//   weight_valid   weight set present on weight (grant of weight_req)
//   weight         one mask bit per element per channel
//   conv_data_in   conv window, shared by all channels
//   fc_data_in     per-channel fc operands
//   out_conv_valid conv result qualifier
//   out_fc_valid   fc result qualifier
//   conv_data_out  per-channel conv sums
//   fc_data_out    per-channel fc results
//   frame_done     pulses with the final fc result of a frame
//
// State table:
//   S_CONV   | accepting conv beats, live weight port used as mask
//   S_WEIGHT | waiting for a weight set grant, no beats accepted
//   S_FC     | accepting one fc beat, latched weight set used as mask
// ----------------------------------------------------------------------------
module conv_fc_engine #(
    parameter int CONV_DW    = 1,
    parameter int FC_DW      = 6,
    parameter int K          = 4,
    parameter int LOGK       = 4,
    parameter int CH_NUM     = 6,
    parameter int CONV_BEATS = 81,
    parameter int FC_BEATS   = 10,
`ifdef CONV_FC_ACC_EN
    localparam int FCW       = FC_DW + LOGK + $clog2(FC_BEATS)
`else
    localparam int FCW       = FC_DW + LOGK
`endif
) (
    input  logic                             clk,
    input  logic                             rstn,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             weight_req,
    input  logic                             weight_valid,
    input  logic [CH_NUM*K*K-1:0]            weight,
    input  logic [K*K*CONV_DW-1:0]           conv_data_in,
    input  logic [CH_NUM*K*K*FC_DW-1:0]      fc_data_in,
    output logic                             out_conv_valid,
    output logic                             out_fc_valid,
    output logic [CH_NUM*(CONV_DW+LOGK)-1:0] conv_data_out,
    output logic [CH_NUM*FCW-1:0]            fc_data_out,
    output logic                             frame_done
);

    localparam int NE  = K * K;
    localparam int CSW = CONV_DW + LOGK;
    localparam int FSW = FC_DW + LOGK;
    localparam int CCW = $clog2(CONV_BEATS + 1);
    localparam int FCC = $clog2(FC_BEATS + 1);

    typedef enum logic [2:0] {
        S_CONV   = 3'b001,
        S_WEIGHT = 3'b010,
        S_FC     = 3'b100
    } state_t;

    state_t state, state_nxt;

    logic [CCW-1:0]         conv_cnt;
    logic [FCC-1:0]         fc_cnt;
    logic [CH_NUM*NE-1:0]   wreg;

    logic                   accept;
    logic                   conv_acc;
    logic                   fc_acc;
    logic                   conv_last;
    logic                   fc_last;

    logic                   s1_conv_v;
    logic                   s1_fc_v;
    logic                   s1_last;
    logic [CH_NUM*NE-1:0]   s1_mask;
    logic [NE*CONV_DW-1:0]  s1_conv;
    logic [CH_NUM*NE*FC_DW-1:0] s1_fc;

    logic [CSW-1:0]         conv_sum [CH_NUM];
    logic [FSW-1:0]         fc_sum   [CH_NUM];

`ifdef CONV_FC_ACC_EN
    logic [FCW-1:0]         acc      [CH_NUM];
`endif

    assign accept    = in_valid & in_ready;
    assign conv_acc  = accept & (state == S_CONV);
    assign fc_acc    = accept & (state == S_FC);
    assign conv_last = (conv_cnt == CCW'(CONV_BEATS - 1));
    assign fc_last   = (fc_cnt == FCC'(FC_BEATS - 1));

    // ------------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state <= S_CONV;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        in_ready   = 1'b0;
        weight_req = 1'b0;
        case (state)
            S_CONV: begin
                in_ready = 1'b1;
                if (in_valid && conv_last) begin
                    state_nxt = S_WEIGHT;
                end
            end
            S_WEIGHT: begin
                weight_req = 1'b1;
                if (weight_valid) begin
                    state_nxt = S_FC;
                end
            end
            S_FC: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = fc_last ? S_CONV : S_WEIGHT;
                end
            end
            default: begin
                state_nxt = S_CONV;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Beat counters and latched fc weight set
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            conv_cnt <= '0;
            fc_cnt   <= '0;
            wreg     <= '0;
        end else begin
            if (conv_acc) begin
                conv_cnt <= conv_last ? '0 : conv_cnt + 1'b1;
            end
            if (fc_acc) begin
                fc_cnt <= fc_last ? '0 : fc_cnt + 1'b1;
            end
            if ((state == S_WEIGHT) && weight_valid) begin
                wreg <= weight;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1: capture the accepted operands together with the mask that
    // applies to them. Conv beats take the live port and fc beats take wreg.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_conv_v <= 1'b0;
            s1_fc_v   <= 1'b0;
            s1_last   <= 1'b0;
            s1_mask   <= '0;
            s1_conv   <= '0;
            s1_fc     <= '0;
        end else begin
            s1_conv_v <= conv_acc;
            s1_fc_v   <= fc_acc;
            s1_last   <= fc_acc & fc_last;
            if (conv_acc || fc_acc) begin
                s1_mask <= conv_acc ? weight : wreg;
                s1_conv <= conv_data_in;
                s1_fc   <= fc_data_in;
            end
        end
    end

    // Masked, zero-extended sums per channel
    always_comb begin
        for (int c = 0; c < CH_NUM; c++) begin
            conv_sum[c] = '0;
            fc_sum[c]   = '0;
            for (int e = 0; e < NE; e++) begin
                if (s1_mask[c*NE + e]) begin
                    conv_sum[c] = conv_sum[c] + CSW'(s1_conv[e*CONV_DW +: CONV_DW]);
                    fc_sum[c]   = fc_sum[c] + FSW'(s1_fc[(c*NE + e)*FC_DW +: FC_DW]);
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: result registers. The data outputs hold their last value.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rstn) begin
            out_conv_valid <= 1'b0;
            out_fc_valid   <= 1'b0;
            frame_done     <= 1'b0;
            conv_data_out  <= '0;
            fc_data_out    <= '0;
`ifdef CONV_FC_ACC_EN
            for (int c = 0; c < CH_NUM; c++) begin
                acc[c] <= '0;
            end
`endif
        end else begin
            out_conv_valid <= s1_conv_v;
            frame_done     <= s1_last;
            if (s1_conv_v) begin
                for (int c = 0; c < CH_NUM; c++) begin
                    conv_data_out[c*CSW +: CSW] <= conv_sum[c];
                end
            end
`ifdef CONV_FC_ACC_EN
            out_fc_valid <= s1_last;
            if (s1_fc_v) begin
                for (int c = 0; c < CH_NUM; c++) begin
                    // The last beat of the frame publishes the total and restarts.
                    if (s1_last) begin
                        fc_data_out[c*FCW +: FCW] <= acc[c] + FCW'(fc_sum[c]);
                        acc[c]                    <= '0;
                    end else begin
                        acc[c] <= acc[c] + FCW'(fc_sum[c]);
                    end
                end
            end
`else
            out_fc_valid <= s1_fc_v;
            if (s1_fc_v) begin
                for (int c = 0; c < CH_NUM; c++) begin
                    fc_data_out[c*FCW +: FCW] <= FCW'(fc_sum[c]);
                end
            end
`endif
        end
    end

endmodule
